alu_exec_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the soft CPU's GPR/ALU datapath.
- Fetches 32-bit instructions from instruction memory over a req/valid handshake and latches them into the IR.
- Issues one execute strobe per instruction to the datapath, stalls on multi-cycle MUL, and stops on HALT.
- Sits between instruction memory and the register-file/ALU block.

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/alu_exec_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_exec_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, IR field positions and sequencer states.
// The STEP_WAIT state exists only when ALU_SEQ_SINGLE_STEP_EN is defined.
package cpu_pkg;

    localparam logic [4:0] OP_MOVSGPR = 5'h00;
    localparam logic [4:0] OP_MOV     = 5'h01;
    localparam logic [4:0] OP_ADD     = 5'h02;
    localparam logic [4:0] OP_SUB     = 5'h03;
    localparam logic [4:0] OP_MUL     = 5'h04;
    localparam logic [4:0] OP_ROR     = 5'h05;
    localparam logic [4:0] OP_RAND    = 5'h06;
    localparam logic [4:0] OP_RXOR    = 5'h07;
    localparam logic [4:0] OP_RXNOR   = 5'h08;
    localparam logic [4:0] OP_RNAND   = 5'h09;
    localparam logic [4:0] OP_RNOR    = 5'h0A;
    localparam logic [4:0] OP_RNOT    = 5'h0B;
    localparam logic [4:0] OP_HALT    = 5'h1F;

    // IR field bit positions shared with the datapath decoder
    localparam int OPER_HI      = 31;
    localparam int OPER_LO      = 27;
    localparam int RDST_HI      = 26;
    localparam int RDST_LO      = 22;
    localparam int RSRC1_HI     = 21;
    localparam int RSRC1_LO     = 17;
    localparam int IMM_MODE_BIT = 16;
    localparam int RSRC2_HI     = 15;
    localparam int RSRC2_LO     = 11;
    localparam int ISRC_HI      = 15;
    localparam int ISRC_LO      = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MUL_WAIT,
        ST_HALT
`ifdef ALU_SEQ_SINGLE_STEP_EN
        , ST_STEP_WAIT
`endif
    } seq_state_e;

    function automatic logic op_is_defined(input logic [4:0] op);
        return op <= OP_RNOT;
    endfunction

endpackage

// File: rtl/alu_exec_sequencer.sv
// Fetch/decode/execute controller for the GPR/ALU datapath.
// Optional single-step gating under ALU_SEQ_SINGLE_STEP_EN.
module alu_exec_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_valid,
    output logic [31:0]      ir,
    output logic             exec_en,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    input  logic             step
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

    seq_state_e      state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [3:0]      mul_cnt;
    logic [4:0]      opcode;

    assign opcode    = ir[OPER_HI:OPER_LO];
    assign imem_addr = pc;

`ifdef ALU_SEQ_SINGLE_STEP_EN
    localparam seq_state_e AFTER_INSN = ST_STEP_WAIT;

    logic step_q;
    logic step_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= step;
    end

    assign step_rise = step & ~step_q;
`else
    localparam seq_state_e AFTER_INSN = ST_FETCH;

    logic step_unused;
    assign step_unused = step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pc      <= '0;
            ir      <= '0;
            illegal <= 1'b0;
            retired <= '0;
            mul_cnt <= '0;
        end else begin
            // NOTE: non-blocking so every register here sees pre-edge values of the others.
            state <= state_nxt;
            if (state == ST_FETCH && imem_valid) begin
                ir <= imem_rdata;
                pc <= pc + 1'b1;
            end
            if (state == ST_DECODE && opcode != OP_HALT && !op_is_defined(opcode))
                illegal <= 1'b1;
            if (state == ST_EXEC) begin
                retired <= retired + 1'b1;
                if (opcode == OP_MUL)
                    mul_cnt <= MUL_LOAD;
            end else if (state == ST_MUL_WAIT && mul_cnt != 4'd0) begin
                mul_cnt <= mul_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_nxt = state;
        imem_req  = 1'b0;
        exec_en   = 1'b0;
        busy      = 1'b1;
        halted    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (opcode == OP_HALT)          state_nxt = ST_HALT;
                else if (!op_is_defined(opcode)) state_nxt = AFTER_INSN;
                else                             state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                exec_en = 1'b1;
                if (opcode == OP_MUL && MUL_LAT > 1) state_nxt = ST_MUL_WAIT;
                else                                 state_nxt = AFTER_INSN;
            end
            ST_MUL_WAIT: begin
                // Leave on the cycle whose decrement brings the counter to zero
                if (mul_cnt <= 4'd1) state_nxt = AFTER_INSN;
            end
            ST_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
`ifdef ALU_SEQ_SINGLE_STEP_EN
            ST_STEP_WAIT: begin
                if (step_rise) state_nxt = ST_FETCH;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Scoreboard bench for alu_exec_sequencer: expected IR per exec_en is queued at
// program load and popped on every exec strobe; a second PC_W=2 instance checks PC wrap.
module tb_alu_exec_sequencer;
    import cpu_pkg::*;

    localparam int PC_W  = 8;
    localparam int CNT_W = 16;

    localparam logic [31:0] I_MOV  = 32'h0801_0005;
    localparam logic [31:0] I_ADD  = 32'h1000_0000;
    localparam logic [31:0] I_MUL  = 32'h2000_0000;
    localparam logic [31:0] I_ILL  = 32'h6000_0000;
    localparam logic [31:0] I_HALT = 32'hF800_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             step = 1'b0;
    logic             imem_req, imem_valid, exec_en, busy, halted, illegal;
    logic [PC_W-1:0]  imem_addr;
    logic [31:0]      imem_rdata, ir;
    logic [CNT_W-1:0] retired;

    logic             start2 = 1'b0;
    logic             req2, exec2, busy2, halted2, illegal2;
    logic [1:0]       addr2;
    logic [31:0]      ir2;
    logic [CNT_W-1:0] retired2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit auto_step = 1'b1;

    logic [31:0] mem [256];
    int          mem_wait = 0;
    int          wait_cnt = 0;

    logic [31:0] exp_ir_q[$];
    int          exec_cnt = 0;
    int          exec_cyc[$];
    int          req_rise_cyc[$];
    int          fetch_addr[$];
    int          stall_log[$];
    int          stall_cnt = 0;
    int          fetch2[$];

    logic             prev_req = 1'b0, prev_valid = 1'b0, prev_exec = 1'b0;
    logic [PC_W-1:0]  prev_addr = '0;
    logic [31:0]      prev_ir = '0;

    alu_exec_sequencer #(.PC_W(PC_W), .MUL_LAT(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .ir(ir), .exec_en(exec_en), .busy(busy),
        .halted(halted), .illegal(illegal), .retired(retired), .step(step)
    );

    alu_exec_sequencer #(.PC_W(2), .MUL_LAT(3), .CNT_W(CNT_W)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .imem_req(req2), .imem_addr(addr2), .imem_rdata(I_ADD),
        .imem_valid(req2), .ir(ir2), .exec_en(exec2), .busy(busy2),
        .halted(halted2), .illegal(illegal2), .retired(retired2), .step(step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Memory model: answers after mem_wait stall cycles, zero wait means same cycle
    assign imem_valid = imem_req && (wait_cnt >= mem_wait);
    assign imem_rdata = mem[imem_addr];

    always @(posedge clk) begin
        if (imem_req && !imem_valid) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end

    // Step toggles continuously unless a test takes manual control
    initial forever begin
        @(negedge clk);
        if (auto_step) step = ~step;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (exec_en) begin
                exec_cnt++;
                exec_cyc.push_back(cyc);
                check("exec_expected", exp_ir_q.size() > 0, 1'b1);
                if (exp_ir_q.size() > 0) check("exec_ir", ir, exp_ir_q.pop_front());
                check("exec_not_back_to_back", prev_exec, 1'b0);
            end
            if (imem_req && !prev_req) req_rise_cyc.push_back(cyc);
            if (prev_req && !prev_valid) begin
                check("req_held", imem_req, 1'b1);
                check("addr_held", imem_addr, prev_addr);
            end
            if (imem_req && !imem_valid) stall_cnt++;
            if (imem_req && imem_valid) begin
                fetch_addr.push_back(int'(imem_addr));
                stall_log.push_back(stall_cnt);
                stall_cnt = 0;
            end
            if (ir !== prev_ir && !(prev_req && prev_valid))
                check("ir_only_on_fetch", ir, prev_ir);
        end
        if (req2) fetch2.push_back(int'(addr2));
        prev_req   = imem_req;
        prev_valid = imem_valid;
        prev_exec  = exec_en;
        prev_addr  = imem_addr;
        prev_ir    = ir;
    end

    task automatic clear_logs();
        exp_ir_q.delete();
        exec_cyc.delete();
        req_rise_cyc.delete();
        fetch_addr.delete();
        stall_log.delete();
        fetch2.delete();
        exec_cnt  = 0;
        stall_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic load_prog(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
        foreach (mem[i]) mem[i] = I_HALT;
        mem[0] = p0;
        mem[1] = p1;
        mem[2] = p2;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_halted"}, halted, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise;
        int n;

        // Reset state
        do_reset();
        #2;
        check("rst_state_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_retired", retired, '0);
        check("rst_ir", ir, '0);
        check("rst_req", imem_req, 1'b0);
        check("rst_exec", exec_en, 1'b0);
        check("rst_pc", imem_addr, '0);

        // Basic program, zero-wait memory
        mem_wait = 0;
        load_prog(I_MOV, I_ADD, I_HALT);
        exp_ir_q.push_back(I_MOV);
        exp_ir_q.push_back(I_ADD);
        pulse_start();
        wait_halt("t1", 200);
        check("t1_exec_cnt", exec_cnt, 2);
        check("t1_retired", retired, 16'd2);
        check("t1_pc", imem_addr, 8'd3);
        check("t1_queue_drained", exp_ir_q.size(), 0);
`ifndef ALU_SEQ_SINGLE_STEP_EN
        if (exec_cyc.size() == 2) check("t1_exec_spacing", exec_cyc[1] - exec_cyc[0], 3);
`endif

        // Multi-cycle multiply
        do_reset();
        load_prog(I_MUL, I_ADD, I_HALT);
        exp_ir_q.push_back(I_MUL);
        exp_ir_q.push_back(I_ADD);
        pulse_start();
        wait_halt("t2", 200);
        check("t2_exec_cnt", exec_cnt, 2);
        check("t2_retired", retired, 16'd2);
`ifndef ALU_SEQ_SINGLE_STEP_EN
        rise = -1;
        if (exec_cyc.size() > 0)
            foreach (req_rise_cyc[i])
                if (rise < 0 && req_rise_cyc[i] > exec_cyc[0]) rise = req_rise_cyc[i];
        if (exec_cyc.size() > 0) check("t2_mul_refetch_gap", rise - exec_cyc[0], 3);
`endif

        // Slow memory: five stall cycles on every fetch
        do_reset();
        mem_wait = 5;
        load_prog(I_ADD, I_HALT, I_HALT);
        exp_ir_q.push_back(I_ADD);
        pulse_start();
        repeat (3) @(negedge clk);
        check("t3_req_during_stall", imem_req, 1'b1);
        check("t3_ir_during_stall", ir, '0);
        wait_halt("t3", 300);
        check("t3_stall_cycles", stall_log.size() > 0 ? stall_log[0] : -1, 5);
        check("t3_retired", retired, 16'd1);

        // Undefined opcode is skipped and flagged
        do_reset();
        mem_wait = 0;
        load_prog(I_ILL, I_ADD, I_HALT);
        exp_ir_q.push_back(I_ADD);
        pulse_start();
        wait_halt("t4", 200);
        check("t4_illegal_sticky", illegal, 1'b1);
        check("t4_retired", retired, 16'd1);
        check("t4_exec_cnt", exec_cnt, 1);
        check("t4_second_fetch_addr", fetch_addr.size() > 1 ? fetch_addr[1] : -1, 1);
        check("t4_pc", imem_addr, 8'd3);

        // Reset while a fetch is outstanding
        do_reset();
        mem_wait = 5;
        load_prog(I_ADD, I_HALT, I_HALT);
        pulse_start();
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_fetch_started", imem_req, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_req_dropped", imem_req, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_pc", imem_addr, '0);
        check("t5_ir", ir, '0);
        check("t5_retired", retired, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
        repeat (10) @(negedge clk);
        check("t5_stays_idle", busy, 1'b0);
        check("t5_no_req", imem_req, 1'b0);
        exp_ir_q.push_back(I_ADD);
        pulse_start();
        wait_halt("t5", 300);
        check("t5_restart_retired", retired, 16'd1);

`ifdef ALU_SEQ_SINGLE_STEP_EN
        // Manual stepping: one instruction per step rising edge
        do_reset();
        mem_wait = 0;
        auto_step = 1'b0;
        step = 1'b0;
        load_prog(I_ADD, I_ADD, I_HALT);
        exp_ir_q.push_back(I_ADD);
        exp_ir_q.push_back(I_ADD);
        pulse_start();
        repeat (20) @(negedge clk);
        check("ss_first_exec", exec_cnt, 1);
        check("ss_waiting_busy", busy, 1'b1);
        step = 1'b1;
        repeat (20) @(negedge clk);
        check("ss_second_exec", exec_cnt, 2);
        step = 1'b0;
        repeat (3) @(negedge clk);
        step = 1'b1;
        wait_halt("ss", 50);
        check("ss_exec_total", exec_cnt, 2);
        step = 1'b0;
        auto_step = 1'b1;
`endif

        // PC wrap on a 2-bit program counter
        do_reset();
        @(posedge clk);
        #1 start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        n = 0;
        while (fetch2.size() < 5 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wrap_fetch_count", fetch2.size() >= 5, 1'b1);
        if (fetch2.size() >= 5) begin
            check("wrap_fourth_addr", fetch2[3], 3);
            check("wrap_fifth_addr", fetch2[4], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
